// File: rtl/alu_pkg.sv
// Shared ALU encodings: op codes, RV32I opcodes, and the issue payload layout.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // 75-bit payload carried through the skid buffer
    typedef struct packed {
        logic [31:0] in0;
        logic [31:0] in1;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } issue_t;

endpackage

// File: rtl/alu_issue_skid.sv
// Two-entry FIFO skid buffer; data visible the cycle after push, in order.
// Backpressure: in_rdy is registered (count < 2); entries hold while out_rdy is low.
module alu_issue_skid
    import alu_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   in_vld,
    output logic   in_rdy,
    input  issue_t in_dat,
    output logic   out_vld,
    input  logic   out_rdy,
    output issue_t out_dat
);

    issue_t     mem_q [2];
    issue_t     mem_d [2];
    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       rdy_q, rdy_d;
    logic       push, pop;

    always_comb begin
        push     = in_vld && rdy_q;
        pop      = (count_q != 2'd0) && out_rdy;
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        if (push) begin
            mem_d[wr_ptr_q] = in_dat;
        end
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        // ready is a registered copy of "room left after this edge"
        rdy_d    = (count_d != 2'd2);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdy_q    <= rdy_d;
        end
    end

    assign in_rdy  = rdy_q;
    assign out_vld = (count_q != 2'd0);
    assign out_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_issue.sv
// RV32I integer-ALU decode and issue; results appear one cycle after acceptance.
// Backpressure: 2-entry skid buffer, instr_ready_o drops when both entries are full.
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        alu_valid_o,
    input  logic        alu_ready_i,
    output logic [31:0] alu_in0_o,
    output logic [31:0] alu_in1_o,
    output logic [3:0]  alu_op_o,
    output logic [4:0]  rd_o,
    output logic        rd_we_o,
    output logic        illegal_o
);

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic       b, illegal, force_add;
    issue_t     dec, out;
    logic       unused_rs1_idx;

    assign opcode         = instr_i[6:0];
    assign f3             = instr_i[14:12];
    assign f7             = instr_i[31:25];
    assign unused_rs1_idx = ^instr_i[19:15];

    always_comb begin
        dec.in0   = rs1_data_i;
        dec.in1   = rs2_data_i;
        b         = 1'b0;
        illegal   = 1'b0;
        force_add = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec.in1 = {27'b0, rs2_data_i[4:0]};
                end
                if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    b = 1'b1;
                end else if (f7 != 7'b0000000) begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.in1 = {{20{instr_i[31]}}, instr_i[31:20]};
                if (f3 == 3'b001) begin
                    dec.in1 = {27'b0, instr_i[24:20]};
                    illegal = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    dec.in1 = {27'b0, instr_i[24:20]};
                    b       = instr_i[30];
                    illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                end
            end
            OPC_LUI: begin
                dec.in0   = 32'd0;
                dec.in1   = {instr_i[31:12], 12'b0};
                force_add = 1'b1;
            end
            OPC_AUIPC: begin
                dec.in0   = pc_i;
                dec.in1   = {instr_i[31:12], 12'b0};
                force_add = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // illegal instructions still flow downstream as a harmless ADD with no writeback
        dec.op      = (illegal || force_add) ? ALU_ADD : {b, f3};
        dec.rd      = instr_i[11:7];
        dec.rd_we   = !illegal && (instr_i[11:7] != 5'd0);
        dec.illegal = illegal;
    end

    alu_issue_skid u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .in_vld  (instr_valid_i),
        .in_rdy  (instr_ready_o),
        .in_dat  (dec),
        .out_vld (alu_valid_o),
        .out_rdy (alu_ready_i),
        .out_dat (out)
    );

    assign alu_in0_o = out.in0;
    assign alu_in1_o = out.in1;
    assign alu_op_o  = out.op;
    assign rd_o      = out.rd;
    assign rd_we_o   = out.rd_we;
    assign illegal_o = out.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, backpressure, throughput, async reset.
module tb_alu_issue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_valid_i, instr_ready_o;
    logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
    logic        alu_valid_o, alu_ready_i;
    logic [31:0] alu_in0_o, alu_in1_o;
    logic [3:0]  alu_op_o;
    logic [4:0]  rd_o;
    logic        rd_we_o, illegal_o;

    int n_chk  = 0;
    int n_fail = 0;

    alu_issue dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .instr_i       (instr_i),
        .pc_i          (pc_i),
        .rs1_data_i    (rs1_data_i),
        .rs2_data_i    (rs2_data_i),
        .alu_valid_o   (alu_valid_o),
        .alu_ready_i   (alu_ready_i),
        .alu_in0_o     (alu_in0_o),
        .alu_in1_o     (alu_in1_o),
        .alu_op_o      (alu_op_o),
        .rd_o          (rd_o),
        .rd_we_o       (rd_we_o),
        .illegal_o     (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] in0, input logic [31:0] in1,
                           input logic [3:0] op, input logic [4:0] rd, input logic we,
                           input logic ill);
        chk({tag, ".vld"}, {31'd0, alu_valid_o}, 32'd1);
        chk({tag, ".in0"}, alu_in0_o, in0);
        chk({tag, ".in1"}, alu_in1_o, in1);
        chk({tag, ".op"},  {28'd0, alu_op_o}, {28'd0, op});
        chk({tag, ".rd"},  {27'd0, rd_o}, {27'd0, rd});
        chk({tag, ".we"},  {31'd0, rd_we_o}, {31'd0, we});
        chk({tag, ".ill"}, {31'd0, illegal_o}, {31'd0, ill});
    endtask

    // Called at a negedge with room in the buffer; returns one negedge later.
    task automatic push(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b);
        instr_valid_i = 1'b1;
        instr_i       = ins;
        pc_i          = pc;
        rs1_data_i    = a;
        rs2_data_i    = b;
        @(negedge clk_i);
        instr_valid_i = 1'b0;
    endtask

    initial begin
        rst_i         = 1'b0;
        instr_valid_i = 1'b0;
        instr_i       = 32'd0;
        pc_i          = 32'd0;
        rs1_data_i    = 32'd0;
        rs2_data_i    = 32'd0;
        alu_ready_i   = 1'b1;

        #3;
        chk("rst.vld", {31'd0, alu_valid_o}, 32'd0);
        chk("rst.rdy", {31'd0, instr_ready_o}, 32'd0);
        chk("rst.in0", alu_in0_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        chk("rst.rdy_hold", {31'd0, instr_ready_o}, 32'd0);
        @(negedge clk_i);
        chk("rst.rdy_rise", {31'd0, instr_ready_o}, 32'd1);

        push(32'h002081B3, 32'h0, 32'd5, 32'd7);
        chk_out("add", 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0);
        push(32'h41F0D213, 32'h0, 32'h80000000, 32'd0);
        chk_out("srai", 32'h80000000, 32'h1F, 4'b1101, 5'd4, 1'b1, 1'b0);
        push(32'h12345297, 32'h100, 32'hDEAD, 32'hBEEF);
        chk_out("auipc", 32'h100, 32'h12345000, 4'b0000, 5'd5, 1'b1, 1'b0);
        push(32'hABCDE337, 32'h0, 32'hDEAD, 32'hBEEF);
        chk_out("lui", 32'h0, 32'hABCDE000, 4'b0000, 5'd6, 1'b1, 1'b0);
        push(32'hFFF08493, 32'h0, 32'd10, 32'd0);
        chk_out("addi", 32'd10, 32'hFFFFFFFF, 4'b0000, 5'd9, 1'b1, 1'b0);
        push(32'h00208033, 32'h0, 32'd1, 32'd2);
        chk_out("add_x0", 32'd1, 32'd2, 4'b0000, 5'd0, 1'b0, 1'b0);

        push(32'h00012083, 32'h0, 32'd1, 32'd2);
        chk("load.ill", {31'd0, illegal_o}, 32'd1);
        chk("load.we",  {31'd0, rd_we_o}, 32'd0);
        chk("load.op",  {28'd0, alu_op_o}, 32'd0);
        push(32'h022081B3, 32'h0, 32'd1, 32'd2);
        chk("mul.ill", {31'd0, illegal_o}, 32'd1);
        chk("mul.we",  {31'd0, rd_we_o}, 32'd0);
        push(32'h40109093, 32'h0, 32'd1, 32'd2);
        chk("slli_f7.ill", {31'd0, illegal_o}, 32'd1);

        // back-to-back: SUB then SLL (rs2 masked to 5 bits)
        instr_valid_i = 1'b1;
        instr_i = 32'h402083B3; rs1_data_i = 32'd9; rs2_data_i = 32'd4;
        @(negedge clk_i);
        chk_out("sub", 32'd9, 32'd4, 4'b1000, 5'd7, 1'b1, 1'b0);
        chk("b2b.rdy", {31'd0, instr_ready_o}, 32'd1);
        instr_i = 32'h00209433; rs1_data_i = 32'd1; rs2_data_i = 32'h123;
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        chk_out("sll", 32'd1, 32'd3, 4'b0001, 5'd8, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("b2b.empty", {31'd0, alu_valid_o}, 32'd0);

        // backpressure: three offered, two accepted, then drain
        alu_ready_i   = 1'b0;
        instr_valid_i = 1'b1;
        instr_i = 32'h002081B3; rs1_data_i = 32'h11; rs2_data_i = 32'd1;
        @(negedge clk_i);
        chk("bp.rdy1", {31'd0, instr_ready_o}, 32'd1);
        instr_i = 32'hFFF08493; rs1_data_i = 32'h22;
        @(negedge clk_i);
        chk("bp.full", {31'd0, instr_ready_o}, 32'd0);
        instr_i = 32'hABCDE337; rs1_data_i = 32'h33;
        @(negedge clk_i);
        chk("bp.full2", {31'd0, instr_ready_o}, 32'd0);
        chk("bp.head_in0", alu_in0_o, 32'h11);
        chk("bp.head_rd", {27'd0, rd_o}, 32'd3);
        @(negedge clk_i);
        chk("bp.stable_in0", alu_in0_o, 32'h11);
        chk("bp.stable_vld", {31'd0, alu_valid_o}, 32'd1);
        instr_valid_i = 1'b0;
        alu_ready_i   = 1'b1;
        @(negedge clk_i);
        chk("bp.rdy_rise", {31'd0, instr_ready_o}, 32'd1);
        chk("bp.second_in0", alu_in0_o, 32'h22);
        chk("bp.second_rd", {27'd0, rd_o}, 32'd9);
        chk("bp.second_vld", {31'd0, alu_valid_o}, 32'd1);
        @(negedge clk_i);
        chk("bp.drained", {31'd0, alu_valid_o}, 32'd0);

        // async reset with both entries full
        alu_ready_i   = 1'b0;
        instr_valid_i = 1'b1;
        instr_i = 32'h002081B3; rs1_data_i = 32'h44;
        @(negedge clk_i);
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        chk("ar.full", {31'd0, instr_ready_o}, 32'd0);
        #2 rst_i = 1'b0;
        #1;
        chk("ar.vld", {31'd0, alu_valid_o}, 32'd0);
        chk("ar.rdy", {31'd0, instr_ready_o}, 32'd0);
        chk("ar.in0", alu_in0_o, 32'd0);
        chk("ar.rd",  {27'd0, rd_o}, 32'd0);
        @(negedge clk_i);
        rst_i       = 1'b1;
        alu_ready_i = 1'b1;
        @(negedge clk_i);
        chk("ar.rdy_rise", {31'd0, instr_ready_o}, 32'd1);
        chk("ar.discard",  {31'd0, alu_valid_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 and buffer depth at 2.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 instr_valid_i  input  1  upstream instruction valid.
REQ-005 instr_ready_o  output  1  block can accept an instruction this cycle.
REQ-006 instr_i  input  32  RV32I instruction word.
REQ-007 pc_i  input  32  address of instr_i.
REQ-008 rs1_data_i  input  32  register-file value for instr_i[19:15].
REQ-009 rs2_data_i  input  32  register-file value for instr_i[24:20].
REQ-010 alu_valid_o  output  1  issued ALU operation valid.
REQ-011 alu_ready_i  input  1  downstream ALU stage accepts the operation.
REQ-012 alu_in0_o  output  32  ALU operand A.
REQ-013 alu_in1_o  output  32  ALU operand B.
REQ-014 alu_op_o  output  4  ALU operation code.
REQ-015 rd_o  output  5  destination register index.
REQ-016 rd_we_o  output  1  result write enable.
REQ-017 illegal_o  output  1  instruction not decodable by this block.

Function
REQ-018 Transfer SHALL occur on a cycle with valid and ready both high, on the input side and the output side independently.
REQ-019 alu_op_o SHALL be {b, funct3} with codes ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
REQ-020 OP (0110011): in0 = rs1, in1 = rs2; b = instr[30] only for funct3 000 or 101, else 0; shifts SHALL mask in1 to {27'b0, rs2[4:0]}.
REQ-021 OP-IMM (0010011): in0 = rs1, in1 = sign-extended instr[31:20]; shifts SHALL use in1 = {27'b0, instr[24:20]}, with b = instr[30] for funct3 101 only.
REQ-022 LUI (0110111): in0 = 0, in1 = {instr[31:12], 12'b0}, op ADD.
REQ-023 AUIPC (0010111): in0 = pc_i, in1 = {instr[31:12], 12'b0}, op ADD.
REQ-024 rd_o = instr[11:7]; rd_we_o = 1 for legal instructions with rd != 0, else 0.
REQ-025 Illegal cases: any other opcode; OP with funct7 other than 0000000, or other than 0100000 with funct3 000/101; OP-IMM shift with non-zero instr[31:25] except instr[30] on funct3 101. Illegal instructions SHALL still issue with illegal_o = 1, op ADD, rd_we_o = 0.
REQ-026 Decoded results SHALL be held in a 2-entry FIFO skid buffer; count in {0, 1, 2}.
REQ-027 instr_ready_o SHALL be registered and equal (count < 2) from the preceding edge.
REQ-028 Latency: an instruction accepted at edge N SHALL appear at the outputs after edge N, in order; alu_valid_o = (count > 0).
REQ-029 Outputs SHALL hold stable while alu_valid_o = 1 and alu_ready_i = 0.
REQ-030 On simultaneous push and pop, count SHALL be unchanged; at count = 2 with a pop, instr_ready_o SHALL rise next cycle.
REQ-031 Back-to-back throughput SHALL be one instruction per cycle while alu_ready_i = 1.

Reset
REQ-032 On rst_i low, regardless of the clock, count = 0, alu_valid_o = 0, instr_ready_o = 0, and all buffered data outputs = 0.
REQ-033 instr_ready_o SHALL rise on the first clock edge after rst_i deasserts; in-flight entries SHALL be discarded on reset.

Structure
REQ-034 Package alu_pkg SHALL hold the ten ALU op codes and the four opcode constants, shared with the ALU.
REQ-035 The FIFO SHALL be sub-module alu_issue_skid (2 entries, 75-bit payload, valid/ready); decode SHALL stay combinational in alu_issue.

Verification
REQ-036 ADD x3, x1, x2 with rs1 = 5, rs2 = 7, alu_ready_i = 1 -> one cycle later in0 = 5, in1 = 7, op 0000, rd 3, rd_we 1.
REQ-037 SRAI x4, x1, 31 (0x41F0D213) with rs1 = 0x80000000 -> op 1101, in1 = 0x0000001F, illegal 0.
REQ-038 AUIPC x5, 0x12345 at pc 0x100 -> in0 = 0x100, in1 = 0x12345000, op 0000.
REQ-039 Hold alu_ready_i = 0 and push 3 instructions -> the first 2 are accepted, instr_ready_o = 0 and outputs stable; release ready -> all 2 drain in order, one per cycle.
REQ-040 Opcode 0000011 (load), or OP with funct7 0000001 -> illegal_o = 1, rd_we_o = 0.
REQ-041 Assert rst_i low mid-stream with count = 2 -> alu_valid_o = 0 immediately, without waiting for a clock edge.
